uart_cmd_sender: RTL and testbench

- Transmit-side counterpart of the two-byte command receiver.
- Accepts a 16-bit command on a single-cycle request and serializes it on one UART TX line as two back-to-back 8N1 frames: high byte first, then low byte.
- Contains its own baud counter, shift register and byte-sequencing FSM.
- Used by the remote/test-host side to drive commands into the design's command receiver.

---
 rtl/uart_cmd_sender.sv | 126 ++++++++++++
 tb/tb_uart_cmd_sender.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sender.sv
// uart_cmd_sender: serializes a 16-bit command as two back-to-back 8N1 UART
// frames on TX, high byte first, then low byte. Each bit lasts BAUD_DIV clocks.
module uart_cmd_sender #(
   parameter int unsigned BAUD_DIV = 5208
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        snd_cmd,
   input  logic [15:0] cmd,
   output logic        TX,
   output logic        busy,
   output logic        cmd_snt
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned BIT_W = 4;
   localparam int unsigned CMD_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_STOP  = BIT_W'(9);
   localparam logic [BIT_W-1:0] BIT_LAST_DATA = BIT_W'(8);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t             r_state, w_state;
   logic [CNT_W-1:0]   r_baud, w_baud;
   logic [BIT_W-1:0]   r_bit, w_bit;
   logic [BYTE_W-1:0]  r_shift, w_shift;
   logic [CMD_W-1:0]   r_hold, w_hold;
   logic               r_tx, w_tx;
   logic               r_busy, w_busy;
   logic               r_snt, w_snt;
   logic               w_bit_end;

   assign w_bit_end = (r_baud == BAUD_LAST);

   // State and datapath registers; TX is forced idle-high by reset asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_hold  <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_snt   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_baud  <= w_baud;
         r_bit   <= w_bit;
         r_shift <= w_shift;
         r_hold  <= w_hold;
         r_tx    <= w_tx;
         r_busy  <= w_busy;
         r_snt   <= w_snt;
      end
   end

   // Next-state: accept in IDLE, step bits on baud boundaries, chain HIGH->LOW->IDLE.
   always_comb begin
      w_state = r_state;
      w_baud  = r_baud;
      w_bit   = r_bit;
      w_shift = r_shift;
      w_hold  = r_hold;
      w_tx    = r_tx;
      w_busy  = r_busy;
      w_snt   = r_snt;
      case (r_state)
         IDLE: begin
            if (snd_cmd) begin
               w_state = HIGH;
               w_hold  = cmd;
               w_shift = cmd[15:8];
               w_baud  = '0;
               w_bit   = '0;
               w_tx    = 1'b0;
               w_busy  = 1'b1;
               w_snt   = 1'b0;
            end
         end
         HIGH, LOW: begin
            if (!w_bit_end) begin
               w_baud = CNT_W'(r_baud + CNT_W'(1));
            end else begin
               w_baud = '0;
               if (r_bit == BIT_STOP) begin
                  w_bit = '0;
                  if (r_state == HIGH) begin
                     // Low frame start bit follows the high stop bit with no gap.
                     w_state = LOW;
                     w_shift = r_hold[7:0];
                     w_tx    = 1'b0;
                  end else begin
                     w_state = IDLE;
                     w_tx    = 1'b1;
                     w_busy  = 1'b0;
                     w_snt   = 1'b1;
                  end
               end else begin
                  w_bit = BIT_W'(r_bit + BIT_W'(1));
                  if (r_bit == BIT_LAST_DATA) begin
                     w_tx = 1'b1;
                  end else begin
                     w_tx    = r_shift[0];
                     w_shift = {1'b0, r_shift[BYTE_W-1:1]};
                  end
               end
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign TX      = r_tx;
   assign busy    = r_busy;
   assign cmd_snt = r_snt;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Scoreboard bench: stimulus pushes expected words; per-instance receiver
// monitors decode TX frames, check frame timing and pop/compare.
module tb_uart_cmd_sender;

   logic        clk;
   logic        rst4, snd4, tx4, busy4, snt4;
   logic [15:0] cmd4;
   logic        rst2, snd2, tx2, busy2, snt2;
   logic [15:0] cmd2;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp4_q[$];
   logic [15:0] exp2_q[$];

   uart_cmd_sender #(.BAUD_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst4), .snd_cmd(snd4), .cmd(cmd4),
      .TX(tx4), .busy(busy4), .cmd_snt(snt4)
   );

   uart_cmd_sender #(.BAUD_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst2), .snd_cmd(snd2), .cmd(cmd2),
      .TX(tx2), .busy(busy2), .cmd_snt(snt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic g_tx(input bit w);
      return w ? tx2 : tx4;
   endfunction
   function automatic logic g_busy(input bit w);
      return w ? busy2 : busy4;
   endfunction
   function automatic logic g_snt(input bit w);
      return w ? snt2 : snt4;
   endfunction
   function automatic logic g_rst(input bit w);
      return w ? rst2 : rst4;
   endfunction

   // Receiver model: k counts negedges since the accept edge; bit i spans k in [i*bd,(i+1)*bd).
   task automatic run_mon(input bit w, input int bd);
      logic [19:0] fr;
      logic [15:0] word, expv;
      bit aborted, busy_ok;
      forever begin
         @(negedge clk);
         if (g_busy(w) !== 1'b1) continue;
         fr = '0;
         aborted = 1'b0;
         busy_ok = 1'b1;
         for (int k = 0; k < 20 * bd; k++) begin
            if (k > 0) @(negedge clk);
            if (g_rst(w)) begin
               aborted = 1'b1;
               break;
            end
            if (g_busy(w) !== 1'b1 || g_snt(w) !== 1'b0) busy_ok = 1'b0;
            if ((k % bd) == (bd / 2)) fr[k / bd] = g_tx(w);
         end
         if (aborted) continue;
         @(negedge clk);
         chk(w ? "b2_busy_window" : "b4_busy_window", 32'(busy_ok), 32'd1);
         chk(w ? "b2_done_busy" : "b4_done_busy", 32'(g_busy(w)), 32'd0);
         chk(w ? "b2_done_snt" : "b4_done_snt", 32'(g_snt(w)), 32'd1);
         chk(w ? "b2_done_tx" : "b4_done_tx", 32'(g_tx(w)), 32'd1);
         chk(w ? "b2_framing" : "b4_framing",
             32'({fr[0], fr[9], fr[10], fr[19]}), 32'b0101);
         word = {fr[8:1], fr[18:11]};
         if ((w ? exp2_q.size() : exp4_q.size()) == 0) begin
            chk(w ? "b2_unexpected_word" : "b4_unexpected_word", 32'(word), 32'hDEAD_BEEF);
         end else begin
            expv = w ? exp2_q.pop_front() : exp4_q.pop_front();
            chk(w ? "b2_word" : "b4_word", 32'(word), 32'(expv));
         end
      end
   endtask

   initial run_mon(1'b0, 4);
   initial run_mon(1'b1, 2);

   task automatic send4(input logic [15:0] c, input bit push);
      @(negedge clk);
      snd4 = 1'b1;
      cmd4 = c;
      if (push) exp4_q.push_back(c);
      @(negedge clk);
      snd4 = 1'b0;
   endtask

   task automatic send2(input logic [15:0] c);
      @(negedge clk);
      snd2 = 1'b1;
      cmd2 = c;
      exp2_q.push_back(c);
      @(negedge clk);
      snd2 = 1'b0;
   endtask

   task automatic wait_idle(input bit w, input string name);
      int n;
      n = 0;
      while (g_busy(w) !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk(name, 32'(g_busy(w)), 32'd0);
   endtask

   initial begin
      rst4 = 1'b1; snd4 = 1'b0; cmd4 = '0;
      rst2 = 1'b1; snd2 = 1'b0; cmd2 = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx4), 32'd1);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_snt", 32'(snt4), 32'd0);
      rst4 = 1'b0;
      rst2 = 1'b0;

      // Basic send
      send4(16'hA53C, 1'b1);
      wait_idle(1'b0, "basic_timeout");
      repeat (2) @(negedge clk);

      // Request while busy is ignored
      send4(16'h1234, 1'b1);
      repeat (36) @(negedge clk);
      snd4 = 1'b1;
      cmd4 = 16'hFFFF;
      @(negedge clk);
      snd4 = 1'b0;
      chk("ign_busy", 32'(busy4), 32'd1);
      chk("ign_snt", 32'(snt4), 32'd0);
      wait_idle(1'b0, "ign_timeout");
      repeat (100) @(negedge clk);
      chk("ign_no_resend", 32'(busy4), 32'd0);

      // cmd changes right after accept
      send4(16'h8001, 1'b1);
      cmd4 = 16'h0000;
      wait_idle(1'b0, "chg_timeout");
      repeat (2) @(negedge clk);

      // Back-to-back with snd_cmd held high
      @(negedge clk);
      snd4 = 1'b1;
      cmd4 = 16'h00FF;
      exp4_q.push_back(16'h00FF);
      @(negedge clk);
      cmd4 = 16'hFF00;
      exp4_q.push_back(16'hFF00);
      wait_idle(1'b0, "b2b_timeout");
      chk("b2b_gap_snt", 32'(snt4), 32'd1);
      chk("b2b_gap_tx", 32'(tx4), 32'd1);
      @(negedge clk);
      chk("b2b_second_busy", 32'(busy4), 32'd1);
      chk("b2b_second_snt", 32'(snt4), 32'd0);
      snd4 = 1'b0;
      wait_idle(1'b0, "b2b2_timeout");
      repeat (2) @(negedge clk);

      // Reset mid-frame while TX is low
      send4(16'h0F0F, 1'b0);
      repeat (30) @(negedge clk);
      chk("mid_tx_pre", 32'(tx4), 32'd0);
      #2 rst4 = 1'b1;
      #1;
      chk("mid_rst_tx", 32'(tx4), 32'd1);
      chk("mid_rst_busy", 32'(busy4), 32'd0);
      chk("mid_rst_snt", 32'(snt4), 32'd0);
      repeat (2) @(negedge clk);
      rst4 = 1'b0;
      send4(16'hC3A5, 1'b1);
      wait_idle(1'b0, "post_rst_timeout");
      repeat (2) @(negedge clk);

      // Extremes at BAUD_DIV=2
      send2(16'h0000);
      wait_idle(1'b1, "ext0_timeout");
      repeat (2) @(negedge clk);
      send2(16'hFFFF);
      wait_idle(1'b1, "ext1_timeout");
      repeat (5) @(negedge clk);

      chk("q4_empty", 32'(exp4_q.size()), 32'd0);
      chk("q2_empty", 32'(exp2_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
